alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RR_INIT, default 0: requester holding round-robin priority after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 reqN_valid  in  1  requester N (N=0,1) has an operation pending.
REQ-005 reqN_ready  out  1  arbiter accepts requester N this cycle.
REQ-006 reqN_cmd  in  4  ALU command: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR.
REQ-007 reqN_val1, reqN_val2  in  32 each  operands.
REQ-008 reqN_s  in  1  update status flags on completion.
REQ-009 rspN_valid  out  1  result available for requester N.
REQ-010 rspN_ready  in  1  requester N consumes result.
REQ-011 rsp_result  out  32  result of the granted operation, shared by both response ports.
REQ-012 rsp_flags  out  4  {N,Z,C,V} of the granted operation.
REQ-013 alu_cmd, alu_val1, alu_val2, alu_carry_in  out  4/32/32/1  registered drive to the shared combinational ALU.
REQ-014 alu_out, alu_carry  in  32/1  ALU result and carry-out.
REQ-015 status  out  4  architectural {N,Z,C,V} register.

Function
REQ-016 FSM states: IDLE, EXEC, RESP; exactly one operation in flight.
REQ-017 IDLE: reqN_ready = reqN_valid AND grant(N); all other states: both ready low.
REQ-018 Grant: if only one valid, that one; if both, the priority holder. Priority toggles to the other requester on every response handshake.
REQ-019 IDLE with any valid: latch cmd, val1, val2, s, and requester id into alu_* / internal registers; alu_carry_in = status[1] at that edge; go to EXEC.
REQ-020 EXEC: capture alu_out into rsp_result; flags N=alu_out[31], Z=(alu_out==0), C=alu_carry; go to RESP.
REQ-021 V: ADD/ADC = operand signs equal AND result sign differs; SUB/SBC = operand signs differ AND result sign differs from val1; other cmds V=0.
REQ-022 C for MOV, MVN, AND, ORR, EOR = current status[1] (unchanged), not alu_carry.
REQ-023 RESP: rspID_valid high, other rsp_valid low; hold rsp_result/rsp_flags stable until rspID_ready.
REQ-024 RESP with rspID_ready: if latched s=1, status <= rsp_flags in the same edge; go to IDLE.
REQ-025 Latency: request accepted at edge T, rsp_valid high from T+1 through handshake; minimum accept-to-accept spacing 3 cycles.
REQ-026 Undefined cmd (0000, 1010-1111): rsp_result=0, rsp_flags=status, no status update even with s=1; response still issued.
REQ-027 Next operation after an s=1 response samples the updated C (update precedes next issue by at least one edge).
REQ-028 Requester dropping valid before grant: no effect; requests are not queued.
REQ-029 rspN_ready outside RESP or for non-granted N: ignored.

Reset
REQ-030 rst high at an edge: state IDLE, status=0000, priority=RR_INIT, rsp_valid both 0, rsp_result=0, rsp_flags=0, alu_* outputs=0.
REQ-031 rst mid-operation (EXEC or RESP): operation discarded, no status update, no response.
REQ-032 rst dominates simultaneous valid/ready inputs.

Verification
REQ-033 Single ADD: req0 val1=0x7FFFFFFF, val2=1, s=1 -> rsp0_valid at T+1, result 0x80000000, flags N1 Z0 C0 V1; status=1001 after handshake.
REQ-034 Contention: req0 and req1 valid same cycle after reset (RR_INIT=0) -> req0 served first, req1 next, then with both held, order alternates 0,1,0,1.
REQ-035 Carry chain: SUB 5-5 s=1 (C=1, Z=1) then ADC 1+1 -> alu_carry_in=1, result 3.
REQ-036 Backpressure: rsp1_ready low 10 cycles -> rsp1_valid and result stable, both req_ready low, no status change until ready.
REQ-037 s=0 and undefined cmd 1111 with s=1 -> status unchanged; undefined gives result 0.
REQ-038 rst asserted in RESP -> next cycle rsp_valid 0, status unchanged, IDLE accepts new request.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester round-robin front end for a shared combinational ALU.
//   One operation is in flight at a time: IDLE accepts a request and
//   registers its operands onto the ALU, EXEC captures the ALU result and
//   computes {N,Z,C,V}, RESP presents the result to the granted requester
//   until it is consumed, optionally updating the status register.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/ready              request handshake, N = 0,1
//   reqN_cmd, reqN_val1/val2      ALU command and operands
//   reqN_s                        update status flags on completion
//   rspN_valid/ready              response handshake, N = 0,1
//   rsp_result, rsp_flags         shared response data and {N,Z,C,V}
//   alu_cmd/val1/val2/carry_in    registered drive to the external ALU
//   alu_out, alu_carry            external ALU result and carry-out
//   status                        architectural {N,Z,C,V} register
module alu_arbiter #(
  parameter int RR_INIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_cmd,
  input  logic [31:0] req0_val1,
  input  logic [31:0] req0_val2,
  input  logic        req0_s,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_cmd,
  input  logic [31:0] req1_val1,
  input  logic [31:0] req1_val2,
  input  logic        req1_s,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [3:0]  alu_cmd,
  output logic [31:0] alu_val1,
  output logic [31:0] alu_val2,
  output logic        alu_carry_in,
  input  logic [31:0] alu_out,
  input  logic        alu_carry,
  output logic [3:0]  status
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_next;
  logic   prio;
  logic   cur_id;
  logic   cur_s;
  logic   grant_id;
  logic   any_valid;
  logic   handshake;
  logic   cmd_defined;
  logic   exec_c;
  logic   exec_v;

  // Next-state, handshake and grant decode.
  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    handshake  = 1'b0;
    any_valid  = req0_valid | req1_valid;
    // Contention goes to the priority holder, otherwise whoever is valid.
    grant_id   = (req0_valid && req1_valid) ? prio : req1_valid;
    case (state)
      IDLE: begin
        req0_ready = req0_valid && !grant_id;
        req1_ready = req1_valid && grant_id;
        if (any_valid) state_next = EXEC;
      end
      EXEC: state_next = RESP;
      RESP: begin
        rsp0_valid = !cur_id;
        rsp1_valid = cur_id;
        handshake  = cur_id ? rsp1_ready : rsp0_ready;
        if (handshake) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Flag derivation for the command currently driven onto the ALU.
  // Logical/move commands keep the architectural carry.
  always_comb begin
    cmd_defined = (alu_cmd >= 4'd1) && (alu_cmd <= 4'd9);
    exec_c      = status[1];
    exec_v      = 1'b0;
    case (alu_cmd)
      4'b0010, 4'b0011: begin
        exec_c = alu_carry;
        exec_v = (alu_val1[31] == alu_val2[31]) && (alu_out[31] != alu_val1[31]);
      end
      4'b0100, 4'b0101: begin
        exec_c = alu_carry;
        exec_v = (alu_val1[31] != alu_val2[31]) && (alu_out[31] != alu_val1[31]);
      end
      default: begin
        exec_c = status[1];
        exec_v = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operation, response and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio         <= (RR_INIT != 0);
      cur_id       <= 1'b0;
      cur_s        <= 1'b0;
      alu_cmd      <= 4'd0;
      alu_val1     <= 32'd0;
      alu_val2     <= 32'd0;
      alu_carry_in <= 1'b0;
      rsp_result   <= 32'd0;
      rsp_flags    <= 4'd0;
      status       <= 4'd0;
    end else begin
      if (state == IDLE && any_valid) begin
        cur_id       <= grant_id;
        cur_s        <= grant_id ? req1_s    : req0_s;
        alu_cmd      <= grant_id ? req1_cmd  : req0_cmd;
        alu_val1     <= grant_id ? req1_val1 : req0_val1;
        alu_val2     <= grant_id ? req1_val2 : req0_val2;
        alu_carry_in <= status[1];
      end
      if (state == EXEC) begin
        if (cmd_defined) begin
          rsp_result <= alu_out;
          rsp_flags  <= {alu_out[31], (alu_out == 32'd0), exec_c, exec_v};
        end else begin
          rsp_result <= 32'd0;
          rsp_flags  <= status;
        end
      end
      if (handshake) begin
        prio <= ~prio;
        // alu_cmd is still latched in RESP, so undefined commands never write status.
        if (cur_s && cmd_defined) status <= rsp_flags;
      end
    end
  end

endmodule
